ccip_c0_rd_arb: RTL and testbench
=================================

CCIP_C0_RD_ARB -- requirements
Module: ccip_c0_rd_arb

Interface
REQ-001 Parameter NUM_REQ, default 4, number of read requesters; SHALL be a power of 2 in the range 2..8.
REQ-002 Parameter L_NUM_REQ, default $clog2(NUM_REQ), requester index width.
REQ-003 Parameter MAX_RDS, default 128, maximum outstanding read cachelines.
REQ-004 Parameter TXHDR_W, default 74, CCI-P TX header width: mdata [15:0], addr [57:16], req [67:64], length [69:68], sop [71], vcsel [73:72].
REQ-005 Parameter RXHDR_W, default 28, CCI-P RX header width: mdata [15:0], req [19:16], clnum [21:20].
REQ-006 Port Clk_400, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-007 Port SoftReset, input, 1 bit: reset, synchronous and active-high.
REQ-008 Port req_valid, input, NUM_REQ bits: per-requester read request pending.
REQ-009 Port req_hdr, input, NUM_REQ*TXHDR_W bits: per-requester TX header; slice i is [i*TXHDR_W +: TXHDR_W].
REQ-010 Port req_ready, output, NUM_REQ bits: one-hot grant; a request is accepted when req_valid[i] and req_ready[i] are both high.
REQ-011 Port C0TxAlmFull, input, 1 bit: TX channel 0 almost full.
REQ-012 Port tx_c0_hdr, output, TXHDR_W bits: issued read header.
REQ-013 Port tx_c0_rdvalid, output, 1 bit: tx_c0_hdr is valid.
REQ-014 Port rx_c0_hdr, input, RXHDR_W bits: read response header.
REQ-015 Port rx_c0_rdvalid, input, 1 bit: read response valid.
REQ-016 Port rsp_valid, output, NUM_REQ bits: one-hot response routed to the requester.
REQ-017 Port rsp_hdr, output, RXHDR_W bits: routed response header.
REQ-018 Port outstanding, output, $clog2(MAX_RDS)+1 bits: count of cachelines currently in flight.
REQ-019 Port err_underflow, output, 1 bit: sticky flag, set when a response arrives while outstanding is 0.

Function
REQ-020 Request cost SHALL be len+1 cachelines, where len = req_hdr slice [69:68] (values 0..3 give 1..4 lines).
REQ-021 Candidate selection SHALL be the first i with req_valid[i]=1, searching upward from rr_ptr and wrapping modulo NUM_REQ.
REQ-022 The candidate SHALL be granted only if C0TxAlmFull=0 and outstanding + cost <= MAX_RDS.
REQ-023 If the candidate does not fit its credit cost, there SHALL be no grant that cycle and the next requester SHALL NOT be tried; this prevents starvation of long requests.
REQ-024 req_ready SHALL be combinational, carry at most one bit high per cycle, and be 0 for every requester with req_valid=0.
REQ-025 On a grant to requester i, rr_ptr SHALL become (i+1) mod NUM_REQ; with no grant, rr_ptr SHALL hold.
REQ-026 A request granted in cycle N SHALL appear on tx_c0_hdr with tx_c0_rdvalid=1 in cycle N+1 only. The header is req_hdr[i] with mdata[15:16-L_NUM_REQ] replaced by i; all other bits pass through unchanged.
REQ-027 Requester mdata bits [15:16-L_NUM_REQ] are reserved and their input values SHALL be ignored.
REQ-028 Response index SHALL be rx_c0_hdr[15:16-L_NUM_REQ].
REQ-029 rx_c0_rdvalid=1 in cycle N SHALL produce rsp_valid[index]=1 in cycle N+1 only. rsp_hdr SHALL equal rx_c0_hdr with the reserved mdata bits cleared to 0.
REQ-030 Each response SHALL return exactly 1 credit.
REQ-031 outstanding_next SHALL equal outstanding + (grant ? cost : 0) - (rsp ? 1 : 0), with grant and response in the same cycle both applied.
REQ-032 The credit check in REQ-022 SHALL use the registered outstanding value and not count a same-cycle response.
REQ-033 A response while outstanding=0 SHALL route normally, SHALL set err_underflow, and outstanding SHALL stay 0 (no wrap).
REQ-034 Once set, err_underflow SHALL clear only on SoftReset.
REQ-035 When tx_c0_rdvalid=0, tx_c0_hdr SHALL hold its last value. When rsp_valid=0, rsp_hdr SHALL hold its last value.

Reset
REQ-036 While SoftReset=1, the following SHALL be 0 on the next edge: tx_c0_rdvalid, tx_c0_hdr, rsp_valid, rsp_hdr, outstanding, err_underflow, rr_ptr. req_ready SHALL be forced to 0.
REQ-037 Reset mid-operation SHALL discard in-flight accounting. Responses to pre-reset requests arriving after reset SHALL route per REQ-029 and SHALL set err_underflow per REQ-033.

Verification
REQ-038 Round-robin: all 4 req_valid high, len=0, 8 cycles -> grants in order 0,1,2,3,0,1,2,3; outstanding=8; each tx_c0_hdr mdata[15:14] equals the grantee index.
REQ-039 Credit limit: outstanding=126, candidate len=3 (cost 4) -> no grant and the next requester is not granted. After 2 responses (outstanding=124) -> grant, and outstanding=128 the following cycle.
REQ-040 Almost full: C0TxAlmFull=1 for 5 cycles with all requests valid -> req_ready=0 and tx_c0_rdvalid=0 throughout; rr_ptr unchanged. First grant after deassertion goes to the rr_ptr requester.
REQ-041 Same cycle: outstanding=10, grant with len=1 plus one response in the same cycle -> outstanding=11. The response with mdata=16'hC005 -> rsp_valid=4'b1000 and rsp_hdr mdata=16'h0005 one cycle later.
REQ-042 Underflow and reset: response with outstanding=0 -> err_underflow=1 and outstanding stays 0. Flag persists for 10 cycles. SoftReset for 1 cycle -> all outputs 0.

Source files
------------

// File: rtl/ccip_c0_rd_arb.sv
// ccip_c0_rd_arb
// Round-robin arbiter that merges NUM_REQ read requesters onto CCI-P TX
// channel 0. It tracks the cachelines in flight and grants a request only
// when the whole request still fits under MAX_RDS. The top mdata bits tag
// each request with its requester index, so responses can be routed back
// on RX channel 0.
//
// Ports
//   Clk_400        : clock, rising edge
//   SoftReset      : synchronous active-high reset
//   req_valid/hdr  : per-requester read request and TX header (slice i)
//   req_ready      : one-hot combinational grant
//   C0TxAlmFull    : TX channel 0 backpressure
//   tx_c0_hdr/rdvalid : registered issued read header
//   rx_c0_hdr/rdvalid : read response from the fabric
//   rsp_valid/hdr  : registered one-hot routed response, tag bits cleared
//   outstanding    : cachelines in flight
//   err_underflow  : sticky, set when a response arrives with nothing in flight
module ccip_c0_rd_arb #(
  parameter int NUM_REQ   = 4,
  parameter int L_NUM_REQ = $clog2(NUM_REQ),
  parameter int MAX_RDS   = 128,
  parameter int TXHDR_W   = 74,
  parameter int RXHDR_W   = 28
) (
  input  logic                         Clk_400,
  input  logic                         SoftReset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*TXHDR_W-1:0]   req_hdr,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         C0TxAlmFull,
  output logic [TXHDR_W-1:0]           tx_c0_hdr,
  output logic                         tx_c0_rdvalid,
  input  logic [RXHDR_W-1:0]           rx_c0_hdr,
  input  logic                         rx_c0_rdvalid,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [RXHDR_W-1:0]           rsp_hdr,
  output logic [$clog2(MAX_RDS):0]     outstanding,
  output logic                         err_underflow
);

  localparam int OUT_W = $clog2(MAX_RDS) + 1;
  localparam int MD_LO = 16 - L_NUM_REQ;

  logic [L_NUM_REQ-1:0] rr_ptr_q, rr_ptr_d;
  logic [TXHDR_W-1:0]   tx_hdr_q, tx_hdr_d;
  logic                 tx_valid_q, tx_valid_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [RXHDR_W-1:0]   rsp_hdr_q, rsp_hdr_d;
  logic [OUT_W-1:0]     outstanding_q, outstanding_d;
  logic                 err_q, err_d;

  logic [TXHDR_W-1:0]   hdr_arr [NUM_REQ];
  logic [L_NUM_REQ-1:0] probe;
  logic [L_NUM_REQ-1:0] cand_idx;
  logic                 cand_found;
  logic [TXHDR_W-1:0]   cand_hdr;
  logic [TXHDR_W-1:0]   tx_mod;
  logic [2:0]           cand_cost;
  logic                 fit;
  logic                 grant;
  logic [L_NUM_REQ-1:0] rx_idx;
  logic [RXHDR_W-1:0]   rx_clr;
  logic                 underflow_now;
  logic [OUT_W-1:0]     out_sum;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      hdr_arr[i] = req_hdr[i*TXHDR_W +: TXHDR_W];
    end
  end

  // First valid requester at or after rr_ptr, wrapping. Only this candidate
  // is ever considered, so a long request is not starved by short ones.
  always_comb begin
    cand_found = 1'b0;
    cand_idx   = '0;
    probe      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      probe = rr_ptr_q + L_NUM_REQ'(k);
      if (!cand_found && req_valid[probe]) begin
        cand_found = 1'b1;
        cand_idx   = probe;
      end
    end
  end

  always_comb begin
    cand_hdr  = hdr_arr[cand_idx];
    cand_cost = {1'b0, cand_hdr[69:68]} + 3'd1;
    // Credit check uses registered outstanding; a same-cycle response does
    // not help. outstanding never exceeds MAX_RDS, so OUT_W bits cannot wrap.
    fit       = (outstanding_q + OUT_W'(cand_cost)) <= OUT_W'(MAX_RDS);
    grant     = cand_found && !C0TxAlmFull && fit && !SoftReset;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = grant && (cand_idx == L_NUM_REQ'(i));
    end
    tx_mod             = cand_hdr;
    tx_mod[15:MD_LO]   = cand_idx;
  end

  always_comb begin
    rx_idx          = rx_c0_hdr[15:MD_LO];
    rx_clr          = rx_c0_hdr;
    rx_clr[15:MD_LO] = '0;
    underflow_now   = rx_c0_rdvalid && (outstanding_q == '0);
  end

  always_comb begin
    rr_ptr_d   = grant ? cand_idx + L_NUM_REQ'(1) : rr_ptr_q;
    tx_valid_d = grant;
    tx_hdr_d   = grant ? tx_mod : tx_hdr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid_d[i] = rx_c0_rdvalid && (rx_idx == L_NUM_REQ'(i));
    end
    rsp_hdr_d  = rx_c0_rdvalid ? rx_clr : rsp_hdr_q;
    // A response with nothing in flight is routed but returns no credit,
    // so the count stays clamped at zero instead of wrapping.
    out_sum = outstanding_q + (grant ? OUT_W'(cand_cost) : '0);
    if (rx_c0_rdvalid && !underflow_now) begin
      out_sum = out_sum - OUT_W'(1);
    end
    outstanding_d = out_sum;
    err_d         = err_q || underflow_now;
  end

  always_ff @(posedge Clk_400) begin
    if (SoftReset) begin
      rr_ptr_q      <= '0;
      tx_hdr_q      <= '0;
      tx_valid_q    <= 1'b0;
      rsp_valid_q   <= '0;
      rsp_hdr_q     <= '0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      tx_hdr_q      <= tx_hdr_d;
      tx_valid_q    <= tx_valid_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_hdr_q     <= rsp_hdr_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
    end
  end

  assign tx_c0_hdr     = tx_hdr_q;
  assign tx_c0_rdvalid = tx_valid_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_hdr       = rsp_hdr_q;
  assign outstanding   = outstanding_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_ccip_c0_rd_arb.sv
// Bench for ccip_c0_rd_arb: directed stimulus, scoreboard queues for the
// issued TX headers and routed responses, popped by a monitor process.
module tb_ccip_c0_rd_arb;
  localparam int NR = 4;
  localparam int TW = 74;
  localparam int RW = 28;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NR-1:0]  req_valid = '0;
  logic [NR*TW-1:0] req_hdr;
  logic [NR-1:0]  req_ready;
  logic           alm_full = 1'b0;
  logic [TW-1:0]  tx_hdr;
  logic           tx_valid;
  logic [RW-1:0]  rx_hdr = '0;
  logic           rx_valid = 1'b0;
  logic [NR-1:0]  rsp_valid;
  logic [RW-1:0]  rsp_hdr;
  logic [7:0]     outstanding;
  logic           err;

  logic [TW-1:0]  hdr [NR];
  logic [TW-1:0]  tx_q [$];
  logic [NR-1:0]  rv_q [$];
  logic [RW-1:0]  rh_q [$];
  logic [TW-1:0]  last_tx;
  int n_chk = 0;
  int n_fail = 0;
  int cnt = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NR; g++) begin : g_hdr
    assign req_hdr[g*TW +: TW] = hdr[g];
  end

  ccip_c0_rd_arb dut (
    .Clk_400(clk), .SoftReset(rst),
    .req_valid(req_valid), .req_hdr(req_hdr), .req_ready(req_ready),
    .C0TxAlmFull(alm_full),
    .tx_c0_hdr(tx_hdr), .tx_c0_rdvalid(tx_valid),
    .rx_c0_hdr(rx_hdr), .rx_c0_rdvalid(rx_valid),
    .rsp_valid(rsp_valid), .rsp_hdr(rsp_hdr),
    .outstanding(outstanding), .err_underflow(err)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reserved tag bits [15:14] are set to 11 so the index overwrite is visible.
  function automatic logic [TW-1:0] mk(input int len);
    logic [TW-1:0] h;
    cnt++;
    h = '0;
    h[15:0]  = 16'hC000 | 16'(cnt);
    h[57:16] = {10'h155, 32'(cnt * 3)};
    h[63:58] = 6'h2A;
    h[67:64] = 4'h6;
    h[69:68] = 2'(len);
    h[71]    = 1'b1;
    h[73:72] = 2'b01;
    return h;
  endfunction

  function automatic logic [TW-1:0] exp_tx(input logic [TW-1:0] h, input int i);
    logic [TW-1:0] e;
    e = h;
    e[15:14] = 2'(i);
    return e;
  endfunction

  // Inputs already driven at this negedge; g = expected grantee or -1.
  task automatic step_exp(input int g);
    logic [NR-1:0] e;
    #1;
    e = '0;
    if (g >= 0) e[g] = 1'b1;
    chk("req_ready", req_ready, e);
    if (g >= 0) begin
      last_tx = exp_tx(hdr[g], g);
      tx_q.push_back(last_tx);
    end
    @(negedge clk);
  endtask

  task automatic send_rsp(input logic [RW-1:0] h);
    logic [NR-1:0] v;
    logic [RW-1:0] c;
    rx_hdr   = h;
    rx_valid = 1'b1;
    v = '0;
    v[h[15:14]] = 1'b1;
    c = h;
    c[15:14] = 2'b00;
    rv_q.push_back(v);
    rh_q.push_back(c);
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    req_valid = '0;
    rx_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_tx_valid"}, tx_valid, 0);
    chk({tag, "_tx_hdr"}, tx_hdr, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_hdr"}, rsp_hdr, 0);
    chk({tag, "_outstanding"}, outstanding, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (tx_valid) begin
        if (tx_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL tx_unexpected: got hdr %0h expected no issue", tx_hdr);
        end else chk("tx_hdr", tx_hdr, tx_q.pop_front());
      end
      if (|rsp_valid) begin
        if (rv_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL rsp_unexpected: got valid %0h expected none", rsp_valid);
        end else begin
          chk("rsp_valid", rsp_valid, rv_q.pop_front());
          chk("rsp_hdr", rsp_hdr, rh_q.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    for (int i = 0; i < NR; i++) hdr[i] = mk(0);
    repeat (2) @(negedge clk);
    req_valid = '1;
    #1 chk("ready_in_reset", req_ready, 0);
    req_valid = '0;
    chk_zero("reset");
    rst = 1'b0;

    // Round robin across all four
    for (int i = 0; i < NR; i++) hdr[i] = mk(0);
    req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      step_exp(k % 4);
      hdr[k % 4] = mk(0);
    end
    req_valid = '0;
    chk("rr_outstanding", outstanding, 8);
    step_exp(-1);
    chk("tx_hold", tx_hdr, last_tx);
    rst_pulse();

    // Almost full stalls and keeps rr_ptr
    hdr[1] = mk(0);
    req_valid = 4'b0010;
    step_exp(1);
    req_valid = 4'hF;
    alm_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step_exp(-1);
      chk("almfull_tx_valid", tx_valid, 0);
    end
    alm_full = 1'b0;
    step_exp(2);
    req_valid = '0;
    step_exp(-1);
    rst_pulse();

    // Credit limit
    req_valid = 4'b0001;
    for (int k = 0; k < 31; k++) begin
      hdr[0] = mk(3);
      step_exp(0);
    end
    hdr[0] = mk(1);
    step_exp(0);
    req_valid = '0;
    chk("credit_126", outstanding, 126);
    hdr[1] = mk(3);
    hdr[2] = mk(0);
    req_valid = 4'b0110;
    step_exp(-1);
    step_exp(-1);
    send_rsp(28'h5A01234);
    step_exp(-1);
    send_rsp(28'h5A04321);
    step_exp(-1);
    rx_valid = 1'b0;
    chk("credit_124", outstanding, 124);
    step_exp(1);
    chk("credit_128", outstanding, 128);
    req_valid = 4'b0100;
    step_exp(-1);
    chk("credit_full_hold", outstanding, 128);
    req_valid = '0;
    rst_pulse();

    // Grant and response in the same cycle
    req_valid = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      hdr[0] = mk(1);
      step_exp(0);
    end
    chk("same_10", outstanding, 10);
    hdr[1] = mk(1);
    req_valid = 4'b0010;
    send_rsp(28'h12AC005);
    step_exp(1);
    rx_valid = 1'b0;
    req_valid = '0;
    chk("same_11", outstanding, 11);
    step_exp(-1);
    rst_pulse();

    // Underflow, persistence, reset
    send_rsp(28'h0038123);
    step_exp(-1);
    rx_valid = 1'b0;
    chk("uf_err", err, 1);
    chk("uf_outstanding", outstanding, 0);
    for (int k = 0; k < 10; k++) begin
      step_exp(-1);
      chk("uf_sticky", err, 1);
    end
    hdr[3] = mk(2);
    req_valid = 4'b1000;
    step_exp(3);
    req_valid = '0;
    chk("pre_reset_outstanding", outstanding, 3);
    rst_pulse();
    chk_zero("reset2");
    send_rsp(28'h00C0007);
    step_exp(-1);
    rx_valid = 1'b0;
    chk("post_reset_err", err, 1);
    chk("post_reset_outstanding", outstanding, 0);
    step_exp(-1);
    chk("tx_q_empty", tx_q.size(), 0);
    chk("rsp_q_empty", rv_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
